mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, byte-enabled data memory between the CPU load/store
// path (port c) and the debug/program-loader path (port d).
//
// Each access takes two cycles. In ACCESS the winner's gnt pulses and the
// memory strobe is driven. In DONE the winner's rvalid pulses with rdata/err.
// Ties are broken round-robin against the last granted port.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   {c,d}_req/addr/wdata/be   request, byte address, lane-aligned data,
//                             byte enables (4'b0000 = read)
//   {c,d}_gnt             one-cycle pulse, request accepted
//   {c,d}_rvalid          one-cycle pulse, access complete
//   {c,d}_rdata, {c,d}_err    read word and error flag, valid with rvalid
//   mem_en/addr/wdata/we  memory strobe, word address, write data, byte writes
//   mem_rdata             synchronous read data (cycle after mem_en)
module mem_port_arbiter #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  input  logic [3:0]        c_be,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  output logic              c_err,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_we,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic                last_is_d_q, last_is_d_d;   // port granted most recently
  logic                owner_is_d_q, owner_is_d_d; // port owning the current access
  logic                err_q, err_d;
  logic                rd_q, rd_d;                 // current access is a legal read
  logic                mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_we_q, mem_we_d;
  logic                c_gnt_q, c_gnt_d, d_gnt_q, d_gnt_d;
  logic                c_rvalid_q, c_rvalid_d, d_rvalid_q, d_rvalid_d;

  // Arbitration result and the winner's fields.
  logic        pick_d;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;
  logic        be_ok;
  logic        addr_ok;
  logic        legal;

  always_comb begin
    // On a tie the port that was not granted last wins.
    pick_d    = d_req & (~c_req | ~last_is_d_q);
    sel_addr  = pick_d ? d_addr  : c_addr;
    sel_wdata = pick_d ? d_wdata : c_wdata;
    sel_be    = pick_d ? d_be    : c_be;

    case (sel_be)
      4'b0000, 4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: be_ok = 1'b1;
      default:                            be_ok = 1'b0;
    endcase
    // Bits above the word-address field must be clear.
    addr_ok = (sel_addr >> (ADDR_W + 2)) == 32'd0;
    legal   = be_ok & addr_ok;
  end

  always_comb begin
    state_d      = state_q;
    last_is_d_d  = last_is_d_q;
    owner_is_d_d = owner_is_d_q;
    err_d        = err_q;
    rd_d         = rd_q;
    mem_en_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 4'b0000;
    c_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
    c_rvalid_d   = 1'b0;
    d_rvalid_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (c_req | d_req) begin
          state_d      = ACCESS;
          // An illegal access still takes its two cycles but leaves memory
          // untouched; the error is reported in DONE.
          mem_en_d     = legal;
          mem_we_d     = legal ? sel_be : 4'b0000;
          mem_addr_d   = sel_addr[ADDR_W+1:2];
          mem_wdata_d  = sel_wdata;
          c_gnt_d      = ~pick_d;
          d_gnt_d      = pick_d;
          last_is_d_d  = pick_d;
          owner_is_d_d = pick_d;
          err_d        = ~legal;
          rd_d         = legal & (sel_be == 4'b0000);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d    = DONE;
        c_rvalid_d = ~owner_is_d_q;
        d_rvalid_d = owner_is_d_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Asynchronous reset drops the memory strobe at once, aborting a write that
  // memory has not yet clocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_is_d_q  <= 1'b1;
      owner_is_d_q <= 1'b0;
      err_q        <= 1'b0;
      rd_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 4'b0000;
      c_gnt_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
      c_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_is_d_q  <= last_is_d_d;
      owner_is_d_q <= owner_is_d_d;
      err_q        <= err_d;
      rd_q         <= rd_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      c_gnt_q      <= c_gnt_d;
      d_gnt_q      <= d_gnt_d;
      c_rvalid_q   <= c_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign c_gnt     = c_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign c_rvalid  = c_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign c_err     = c_rvalid_q & err_q;
  assign d_err     = d_rvalid_q & err_q;

  // Read data passes straight through from memory during DONE, owner only.
  assign c_rdata = (c_rvalid_q & rd_q) ? mem_rdata : 32'h0;
  assign d_rdata = (d_rvalid_q & rd_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       req_v;
  logic [1:0][31:0] addr_v;
  logic [1:0][31:0] wdata_v;
  logic [1:0][3:0]  be_v;
  wire  [1:0]       gnt_v;
  wire  [1:0]       rvalid_v;
  wire  [1:0]       err_v;
  wire  [1:0][31:0] rdata_v;
  wire              mem_en;
  wire [ADDR_W-1:0] mem_addr;
  wire [31:0]       mem_wdata;
  wire [3:0]        mem_we;
  logic [31:0]      mem_rdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .c_req(req_v[0]), .c_addr(addr_v[0]), .c_wdata(wdata_v[0]), .c_be(be_v[0]),
    .d_req(req_v[1]), .d_addr(addr_v[1]), .d_wdata(wdata_v[1]), .d_be(be_v[1]),
    .c_gnt(gnt_v[0]), .c_rvalid(rvalid_v[0]), .c_rdata(rdata_v[0]), .c_err(err_v[0]),
    .d_gnt(gnt_v[1]), .d_rvalid(rvalid_v[1]), .d_rdata(rdata_v[1]), .d_err(err_v[1]),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Memory stub driven by the DUT; synchronous read, byte-enabled write.
  logic [31:0] env_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) env_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= env_mem[mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: who is granted this cycle, who completes.
  logic [31:0] ref_mem [DEPTH];
  int          exp_g, exp_rv, last;
  logic [31:0] g_addr, g_wdata, g_pred, rv_pred;
  logic [3:0]  g_be;
  logic        g_legal, rv_legal, rv_read;
  logic [1:0]  pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] be, input logic [31:0] a);
    bit be_ok;
    be_ok = be inside {4'b0000, 4'b1111, 4'b0011, 4'b1100,
                       4'b0001, 4'b0010, 4'b0100, 4'b1000};
    return be_ok && (longint'(a) < (longint'(1) << (ADDR_W + 2)));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic model_edge();
    int  w;
    bit  free;
    int  wd;
    if (rst) begin
      exp_g = -1; exp_rv = -1; last = 1;
      return;
    end
    w        = -1;
    free     = (exp_g < 0);
    exp_rv   = exp_g;
    rv_legal = g_legal;
    rv_read  = g_legal && (g_be == 4'b0000);
    rv_pred  = g_pred;
    if (free && req_v != 2'b00) begin
      if (req_v == 2'b11) w = 1 - last;
      else                w = req_v[1] ? 1 : 0;
      last    = w;
      g_addr  = addr_v[w];
      g_wdata = wdata_v[w];
      g_be    = be_v[w];
      g_legal = is_legal(g_be, g_addr);
      g_pred  = 32'h0;
      wd      = word_of(g_addr);
      if (g_legal) begin
        if (g_be == 4'b0000) g_pred = ref_mem[wd];
        else
          for (int b = 0; b < 4; b++)
            if (g_be[b]) ref_mem[wd][8*b +: 8] = g_wdata[8*b +: 8];
      end
    end
    exp_g = w;
  endtask

  task automatic check_cycle();
    bit en_exp;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("gnt[%0d]", p),    {31'b0, gnt_v[p]},    {31'b0, exp_g == p});
      chk($sformatf("rvalid[%0d]", p), {31'b0, rvalid_v[p]}, {31'b0, exp_rv == p});
      chk($sformatf("err[%0d]", p),    {31'b0, err_v[p]},    {31'b0, (exp_rv == p) && !rv_legal});
      chk($sformatf("rdata[%0d]", p),  rdata_v[p], ((exp_rv == p) && rv_read) ? rv_pred : 32'h0);
    end
    en_exp = (exp_g >= 0) && g_legal;
    chk("mem_en", {31'b0, mem_en}, {31'b0, en_exp});
    chk("mem_we", {28'b0, mem_we}, {28'b0, en_exp ? g_be : 4'b0000});
    if (en_exp) chk("mem_addr", {21'b0, mem_addr}, word_of(g_addr));
    if (en_exp && g_be != 4'b0000) chk("mem_wdata", mem_wdata, g_wdata);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
    addr_v[p] = a; be_v[p] = be; wdata_v[p] = wd; req_v[p] = 1'b1;
  endtask

  task automatic random_fields(input int p);
    logic [3:0] be_tab [12];
    be_tab = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6, 4'h5};
    be_v[p]    = be_tab[$urandom_range(0, 11)];
    wdata_v[p] = $urandom;
    if ($urandom_range(0, 15) == 0) addr_v[p] = $urandom;
    else                            addr_v[p] = $urandom_range(0, 255);
  endtask

  task automatic drive_random();
    for (int p = 0; p < 2; p++) begin
      if (gnt_v[p]) pend[p] = 1'b0;
      if (!pend[p] && $urandom_range(0, 2) != 0) begin
        random_fields(p);
        pend[p] = 1'b1;
      end
      req_v[p] = pend[p];
    end
  endtask

  initial begin
    logic [31:0] old_word;
    int          order [$];
    int          t_rv1, t_rv2;
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    env_mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    mem_rdata = 32'h0;
    req_v = 2'b00; addr_v = '0; wdata_v = '0; be_v = '0; pend = 2'b00;
    exp_g = -1; exp_rv = -1; last = 1;
    g_addr = 0; g_wdata = 0; g_pred = 0; g_be = 0; g_legal = 1'b0;
    rv_pred = 0; rv_legal = 1'b1; rv_read = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    chk("reset_outputs", {gnt_v, rvalid_v, err_v, mem_en, mem_we, 21'b0}, 32'h0);
    rst = 1'b0;

    // c read of word 4
    set_req(0, 32'h0000_0010, 4'b0000, 32'h0);
    tick();
    chk("t1_gnt", {31'b0, gnt_v[0]}, 32'd1);
    chk("t1_addr", {21'b0, mem_addr}, 32'd4);
    req_v[0] = 1'b0;
    tick();
    chk("t1_rdata", rdata_v[0], 32'hDEADBEEF);
    tick();

    // d byte store to address 7
    set_req(1, 32'h0000_0007, 4'b1000, 32'h0000_00AB);
    tick();
    chk("t2_we", {28'b0, mem_we}, 32'h8);
    chk("t2_addr", {21'b0, mem_addr}, 32'd1);
    req_v[1] = 1'b0;
    tick();
    chk("t2_rvalid", {31'b0, rvalid_v[1]}, 32'd1);
    tick();

    // Illegal byte-enable pattern, then out-of-range address
    set_req(0, 32'h0000_0020, 4'b0110, 32'h1111_2222);
    tick();
    chk("t4a_en", {31'b0, mem_en}, 32'd0);
    req_v[0] = 1'b0;
    tick();
    chk("t4a_err", {31'b0, err_v[0]}, 32'd1);
    set_req(0, 32'h0001_0000, 4'b1111, 32'h3333_4444);
    tick();
    chk("t4b_we", {28'b0, mem_we}, 32'd0);
    req_v[0] = 1'b0;
    tick();
    chk("t4b_err", {31'b0, err_v[0]}, 32'd1);
    tick();

    // c read followed by a held c read
    set_req(0, 32'h0000_0010, 4'b0000, 32'h0);
    tick();
    set_req(0, 32'h0000_0014, 4'b0000, 32'h0);
    tick();
    t_rv1 = rvalid_v[0] ? 1 : 0;
    tick();
    chk("t6_gnt2", {31'b0, gnt_v[0]}, 32'd1);
    req_v[0] = 1'b0;
    tick();
    t_rv2 = rvalid_v[0] ? 1 : 0;
    chk("t6_rv_pair", t_rv1 + t_rv2, 32'd2);
    chk("t6_rdata2", rdata_v[0], ref_mem[5]);
    tick();

    // Reset during the ACCESS cycle of a full-word write
    old_word = env_mem[16];
    set_req(0, 32'h0000_0040, 4'b1111, 32'h1234_5678);
    tick();
    req_v[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_en", {31'b0, mem_en}, 32'd0);
    chk("t5_we", {28'b0, mem_we}, 32'd0);
    ref_mem[16] = old_word;
    exp_g = -1; exp_rv = -1; last = 1;
    repeat (2) tick();
    chk("t5_mem", env_mem[16], old_word);
    rst = 1'b0;

    // Sustained contention from reset: c, d, c, d ...
    set_req(0, 32'h0000_0000, 4'b0000, 32'h0);
    set_req(1, 32'h0000_0004, 4'b0000, 32'h0);
    for (int k = 0; k < 16; k++) begin
      tick();
      if (gnt_v[0]) order.push_back(0);
      if (gnt_v[1]) order.push_back(1);
      for (int p = 0; p < 2; p++)
        if (gnt_v[p]) addr_v[p] = 32'($urandom_range(0, 63)) << 2;
    end
    chk("t3_count", order.size(), 32'd8);
    for (int k = 0; k < order.size(); k++)
      chk($sformatf("t3_order[%0d]", k), order[k], k % 2);
    req_v = 2'b00;
    repeat (2) tick();

    // Randomised traffic from both ports
    for (int k = 0; k < 800; k++) begin
      tick();
      drive_random();
    end
    req_v = 2'b00;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
